// File: rtl/input_pack_mem_pkg.sv
// Shared constants and state encoding for the frame-memory write path.
package input_pack_mem_pkg;
  localparam int BYTES_PER_WORD = 16;
  localparam int WORD_BITS      = 128;
  localparam int FRAME_WORDS    = 19200;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/input_pack_mem_if.sv
// Upstream byte stream plus frame-memory write port of input_pack_mem.
interface input_pack_mem_if
  import input_pack_mem_pkg::*;
#(
  parameter int ADDR_W = 16
);
  logic                 start;
  logic [7:0]           DataIn;
  logic                 DataValid;
  logic                 input_base_offset;
  logic [ADDR_W-1:0]    WriteAddress;
  logic [WORD_BITS-1:0] WriteBus;
  logic                 WriteEnable;
  logic                 done;

  modport master (
    output start, DataIn, DataValid, input_base_offset,
    input  WriteAddress, WriteBus, WriteEnable, done
  );

  modport slave (
    input  start, DataIn, DataValid, input_base_offset,
    output WriteAddress, WriteBus, WriteEnable, done
  );
endinterface

// File: rtl/input_pack_mem_byte_word_packer.sv
// Packs bytes MSB-first into a 128-bit word; the finished word sits in its own
// holding register so the next group can start filling during the strobe.
module byte_word_packer
  import input_pack_mem_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [7:0]           i_byte,
  output logic [WORD_BITS-1:0] o_word,
  output logic                 o_word_valid
);
  localparam int CNT_W = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

  logic [CNT_W-1:0]     r_cnt;
  logic [WORD_BITS-1:0] r_shift;
  logic [WORD_BITS-1:0] r_word;
  logic                 r_wvld;
  logic [WORD_BITS-1:0] w_ins;

  always_comb begin
    w_ins = r_shift;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (r_cnt == CNT_W'(k)) w_ins[WORD_BITS-1-8*k -: 8] = i_byte;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_word  <= '0;
      r_wvld  <= 1'b0;
    end else begin
      r_wvld <= 1'b0;
      if (i_clr) begin
        r_cnt <= '0;
      end else if (i_en) begin
        r_shift <= w_ins;
        r_cnt   <= r_cnt + CNT_W'(1);
        if (r_cnt == LAST_BYTE) begin
          r_word <= w_ins;
          r_wvld <= 1'b1;
        end
      end
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_wvld;
endmodule

// File: rtl/input_pack_mem.sv
// Frame writer: packs incoming bytes into words and writes them sequentially
// into the memory half chosen by input_base_offset, then signals done.
module input_pack_mem
  import input_pack_mem_pkg::*;
#(
  parameter int WORDS  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input_pack_mem_if.slave   bus
);
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

  state_t               r_state;
  state_t               w_next;
  logic [CNT_W-1:0]     r_wcnt;
  logic [ADDR_W-1:0]    r_addr;
  logic                 w_clr;
  logic                 w_en;
  logic                 w_wvld;
  logic                 w_last;
  logic [WORD_BITS-1:0] w_word;

  assign w_en   = (r_state == FILL) && bus.start && bus.DataValid;
  assign w_clr  = (r_state != FILL);
  assign w_last = (r_wcnt == LAST_WORD);

  byte_word_packer u_packer (
    .clock        (clock),
    .reset        (reset),
    .i_clr        (w_clr),
    .i_en         (w_en),
    .i_byte       (bus.DataIn),
    .o_word       (w_word),
    .o_word_valid (w_wvld)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.start) w_next = FILL;
      FILL: begin
        if (!bus.start)          w_next = IDLE;
        else if (w_wvld && w_last) w_next = DONE;
      end
      DONE: if (!bus.start) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The final word keeps its address so WriteAddress holds it through DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
      r_wcnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_addr <= {bus.input_base_offset, {(ADDR_W-1){1'b0}}};
          r_wcnt <= '0;
        end
        FILL: begin
          if (bus.start && w_wvld) begin
            r_wcnt <= r_wcnt + CNT_W'(1);
            if (!w_last)
              r_addr <= {r_addr[ADDR_W-1], r_addr[ADDR_W-2:0] + (ADDR_W-1)'(1)};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.WriteAddress = r_addr;
  assign bus.WriteBus     = w_word;
  assign bus.WriteEnable  = w_wvld;
  assign bus.done         = (r_state == DONE);
endmodule

// File: tb/tb_input_pack_mem.sv
// Directed/random bench for input_pack_mem with a byte-queue reference model.
module tb_input_pack_mem;
  logic clock;
  logic reset;
  logic t_start, t_valid, t_off;
  logic [7:0] t_data;

  input_pack_mem_if #(.ADDR_W(16)) if16 ();
  input_pack_mem_if #(.ADDR_W(16)) if1 ();

  assign if16.start = t_start;  assign if1.start = t_start;
  assign if16.DataIn = t_data;  assign if1.DataIn = t_data;
  assign if16.DataValid = t_valid; assign if1.DataValid = t_valid;
  assign if16.input_base_offset = t_off; assign if1.input_base_offset = t_off;

  input_pack_mem #(.WORDS(16), .ADDR_W(16)) u_dut16 (.clock(clock), .reset(reset), .bus(if16));
  input_pack_mem #(.WORDS(1),  .ADDR_W(16)) u_dut1  (.clock(clock), .reset(reset), .bus(if1));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Strobe log per DUT, plus the cycle of the latest rise of done.
  logic [15:0]  q16_addr[$], q1_addr[$];
  logic [127:0] q16_bus[$],  q1_bus[$];
  int           q16_cyc[$],  q1_cyc[$];
  int d16_rise = -1, d1_rise = -1;
  logic d16_prev = 1'b0, d1_prev = 1'b0;

  always @(negedge clock) begin
    if (if16.WriteEnable) begin
      q16_addr.push_back(if16.WriteAddress); q16_bus.push_back(if16.WriteBus); q16_cyc.push_back(cyc);
    end
    if (if1.WriteEnable) begin
      q1_addr.push_back(if1.WriteAddress); q1_bus.push_back(if1.WriteBus); q1_cyc.push_back(cyc);
    end
    if (if16.done && !d16_prev) d16_rise <= cyc;
    if (if1.done && !d1_prev)   d1_rise  <= cyc;
    d16_prev <= if16.done;
    d1_prev  <= if1.done;
  end

  // Reference model: accepted bytes in order, and the edge of each 16th byte.
  logic [7:0] frame[$];
  int         edges[$];
  int         b16, b1;
  int         n_chk = 0, n_fail = 0;

  function automatic logic [127:0] pack_word(input int w);
    logic [127:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) acc = {acc[119:0], frame[16*w+i]};
    return acc;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] b, input bit rec);
    t_valid = v;
    t_data  = b;
    @(posedge clock);
    #1;
    if (rec && v) begin
      frame.push_back(b);
      if (frame.size() % 16 == 0) edges.push_back(cyc);
    end
    t_valid = 1'b0;
  endtask

  task automatic new_frame();
    frame.delete();
    edges.delete();
    b16 = q16_addr.size();
    b1  = q1_addr.size();
  endtask

  task automatic check_strobes(input int n, input logic [15:0] base);
    check("strobe_count", 128'(q16_addr.size() - b16), 128'(n));
    for (int w = 0; w < n; w++) begin
      if (b16 + w < q16_addr.size()) begin
        check("strobe_addr",  128'(q16_addr[b16+w]), 128'(base + 16'(w)));
        check("strobe_data",  q16_bus[b16+w], pack_word(w));
        check("strobe_cycle", 128'(q16_cyc[b16+w]), 128'(edges[w]));
      end
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_addr"}, 128'(if16.WriteAddress), 128'(0));
    check({tag, "_bus"},  if16.WriteBus, 128'(0));
    check({tag, "_we"},   128'(if16.WriteEnable), 128'(0));
    check({tag, "_done"}, 128'(if16.done), 128'(0));
  endtask

  initial begin
    clock = 1'b0; reset = 1'b0;
    t_start = 1'b0; t_valid = 1'b0; t_off = 1'b0; t_data = 8'h00;
    #1 reset = 1'b1;
    #1 check_cleared("reset");
    @(posedge clock); @(posedge clock); #1 reset = 1'b0;

    // Single-word frame on the WORDS=1 instance; a byte in the start cycle is dropped.
    new_frame();
    t_off = 1'b0; t_start = 1'b1;
    step(1'b1, 8'hAA, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b0);
    check("w1_count", 128'(q1_addr.size() - b1), 128'(1));
    if (q1_addr.size() > b1) begin
      check("w1_addr",  128'(q1_addr[b1]), 128'(0));
      check("w1_data",  q1_bus[b1], 128'h000102030405060708090A0B0C0D0E0F);
      check("w1_cycle", 128'(q1_cyc[b1]), 128'(edges[0]));
    end
    check("w1_done_rise", 128'(d1_rise), 128'(edges[0] + 1));
    t_start = 1'b0;
    repeat (2) step(1'b0, 8'h00, 1'b0);

    // Full back-to-back frame into the upper half.
    new_frame();
    t_off = 1'b1; t_start = 1'b1;
    step(1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 256; i++) step(1'b1, 8'($urandom), 1'b1);
    repeat (3) step(1'b0, 8'($urandom), 1'b0);
    check_strobes(16, 16'h8000);
    check("full_done_rise", 128'(d16_rise), 128'(edges[15] + 1));
    @(negedge clock);
    check("full_addr_hold", 128'(if16.WriteAddress), 128'(16'h800F));
    check("full_done", 128'(if16.done), 128'(1));
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
    @(negedge clock);
    check("done_hold_nostrobe", 128'(q16_addr.size() - b16), 128'(16));
    check("done_hold_level", 128'(if16.done), 128'(1));
    check("done_hold_addr", 128'(if16.WriteAddress), 128'(16'h800F));
    t_start = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    check("done_clear", 128'(if16.done), 128'(0));

    // Gappy input, offset flipped mid-frame, then abort 10 bytes into word 2.
    new_frame();
    t_off = 1'b1; t_start = 1'b1;
    step(1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 42; i++) begin
      step(1'b1, 8'($urandom), 1'b1);
      step(1'b0, 8'($urandom), 1'b0);
      if (i == 5) t_off = 1'b0;
    end
    t_start = 1'b0;
    repeat (4) step(1'b0, 8'($urandom), 1'b0);
    check_strobes(2, 16'h8000);
    @(negedge clock);
    check("abort_done", 128'(if16.done), 128'(0));
    check("abort_idle_addr", 128'(if16.WriteAddress), 128'(0));

    // Restart in the lower half after the abort.
    new_frame();
    t_start = 1'b1;
    step(1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b1);
    repeat (2) step(1'b0, 8'($urandom), 1'b0);
    check_strobes(1, 16'h0000);

    // Asynchronous reset in the middle of a group, between clock edges.
    for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b0);
    #3 reset = 1'b1;
    #1 check_cleared("async_reset");
    @(posedge clock); #1 reset = 1'b0;
    new_frame();
    t_off = 1'b1;
    step(1'b1, 8'h5A, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b1);
    repeat (2) step(1'b0, 8'($urandom), 1'b0);
    check_strobes(1, 16'h8000);
    t_start = 1'b0;
    repeat (2) step(1'b0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/input_pack_mem.md
# input_pack_mem

Write-side counterpart of the output fetch path. Accepts a frame of 8-bit bytes from the upstream source and packs each group of 16 bytes into one 128-bit word. Writes each word to the frame memory at sequential addresses inside the half selected by `input_base_offset`. Raises `done` when the frame is complete, so the output pipeline can then fetch from that half.

## Interface

Parameters:
- `WORDS`, default 16: 128-bit words per frame (production value 19200).
- `ADDR_W`, default 16: memory address width; MSB is the base-offset bit.

Ports:
- `clock` — input, 1: single clock; all logic is on the rising edge.
- `reset` — input, 1: asynchronous, active-high reset.
- `start` — input, 1: frame enable level; held high for the whole frame.
- `DataIn` — input, 8: incoming byte.
- `DataValid` — input, 1: `DataIn` is valid this cycle.
- `input_base_offset` — input, 1: memory half; sampled in IDLE.
- `WriteAddress` — output, ADDR_W: word address of the current write.
- `WriteBus` — output, 128: packed word.
- `WriteEnable` — output, 1: one-cycle write strobe.
- `done` — output, 1: frame complete; level signal.

## Operation

- Reset value of every output and internal register is 0, including the state (IDLE) and all counters.
- State IDLE:
  - `WriteAddress` <= {`input_base_offset`, 0...}.
  - Byte and word counters are cleared.
  - `start`=1 -> FILL. A `DataValid` in that same cycle is ignored.
- State FILL, accepting bytes:
  - A byte is accepted on each cycle with `DataValid`=1.
  - Byte k of a group (k = 0..15) is stored at `WriteBus`[127-8k -: 8]. The first byte lands in the MSB; the last byte lands in [7:0].
  - The 4-bit byte counter increments per accepted byte and wraps 15 -> 0.
- State FILL, on the 16th accepted byte of a group:
  - Next cycle, `WriteEnable`=1 for exactly one cycle.
  - `WriteBus` carries the full word; `WriteAddress` is the word's address.
  - In the cycle after the strobe, `WriteAddress`[ADDR_W-2:0] increments by 1. The MSB is unchanged.
- Back-to-back bytes: FILL accepts `DataValid` every cycle, including the strobe cycle. Byte 0 of the next group accepted during the strobe cycle must not corrupt the `WriteBus` value being written. Use a separate output holding register.
- Word counter: increments on each `WriteEnable`. When the final strobe (word `WORDS`-1) is issued, the next state is DONE; the address does not increment.
- State DONE:
  - `done`=1 and `DataValid` is ignored.
  - `WriteAddress` holds the last written address.
  - `start`=0 -> IDLE, and `done` drops in that same transition.
- `start`=0 while in FILL (abort):
  - Return to IDLE next cycle; the partial group is discarded.
  - No `WriteEnable` is issued for it. A strobe already scheduled for a completed group is still issued.
  - `done` stays 0.
- `reset` mid-frame: immediate return to IDLE with all outputs 0; no write completes.
- `WriteBus` is don't-care when `WriteEnable`=0. It is held (not cleared) to save toggles.

## Timing

- Latency: 16th byte accepted at edge N -> `WriteEnable` high from N to N+1.
- Address increment is visible from edge N+1.
- `done` is high from the edge after the final `WriteEnable` cycle.
- Maximum throughput: 1 byte per clock, i.e. one word every 16 clocks. No backpressure.
- IDLE -> FILL costs one cycle; bytes offered in the cycle `start` first rises are dropped.
- `input_base_offset` changes outside IDLE have no effect.

## Structure

- Shared package contents:
  - `BYTES_PER_WORD` = 16 and `WORD_BITS` = 128.
  - The state typedef (IDLE, FILL, DONE).
  - The frame-size constant used by both the output fetch block and this block.
- Sub-module `byte_word_packer`: byte counter plus shift/insert register.
  - Outputs a 128-bit word and a one-cycle `word_valid`.
  - Cleared by a sync clear from the FSM.
- Top level holds the FSM, address counter, word counter and `done`.

## Test plan

- Reset then single word (`WORDS`=1):
  - Stimulus: offset=0, `start`=1, then bytes 0x00..0x0F on 16 consecutive cycles.
  - Response: one `WriteEnable` with `WriteBus`=0x000102...0E0F at `WriteAddress`=0x0000; `done`=1 the next cycle.
- Full frame, offset=1, `WORDS`=16, 256 back-to-back bytes:
  - 16 strobes at addresses 0x8000..0x800F, each 16 cycles apart.
  - `done` after the 16th strobe; `WriteAddress` stays 0x800F.
- Gappy input (`DataValid` toggling 1/0): word contents are the same as the gapless case; the strobe comes one cycle after the 16th valid byte.
- Abort: `start` falls after 10 bytes of word 2.
  - No third strobe; back in IDLE, `done`=0.
  - Restart with offset=0 writes from 0x0000.
- Async `reset` pulse mid-group: all outputs 0 immediately, including in the cycle of assertion with no clock edge. The next frame starts clean at the base address.
- DONE hold: extra `DataValid` bytes in DONE produce no strobe. `start`=0 clears `done` next edge.
